// File: rtl/serial_logic_unit_pkg.sv
// Shared encodings for the bit-serial logic/add lane: opcodes and FSM states.
package serial_logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: AND/OR/XOR/full-add of one bit pair.
module serial_alu_slice
    import serial_logic_unit_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r_bit,
    output logic       cout
);

    always_comb begin
        r_bit = 1'b0;
        cout  = 1'b0;
        case (op)
            OP_AND: r_bit = a_bit & b_bit;
            OP_OR:  r_bit = a_bit | b_bit;
            OP_XOR: r_bit = a_bit ^ b_bit;
            OP_ADD: begin
                r_bit = a_bit ^ b_bit ^ cin;
                cout  = (a_bit & b_bit) | (cin & (a_bit ^ b_bit));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial WIDTH-bit AND/OR/XOR/ADD lane, LSB first, with valid/ready in and out.
// Optional signed-overflow output enabled by defining SERIAL_LOGIC_UNIT_OVERFLOW_EN.
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero
`ifdef SERIAL_LOGIC_UNIT_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [1:0]         op_q;
    logic               r_bit, c_next;
    logic [WIDTH-1:0]   res_next;
    logic               accept, last_bit;

    serial_alu_slice u_slice (
        .a_bit (a_sh[0]),
        .b_bit (b_sh[0]),
        .cin   (carry),
        .op    (op_q),
        .r_bit (r_bit),
        .cout  (c_next)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at result[0].
    assign res_next  = {r_bit, result[WIDTH-1:1]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last_bit) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= OP_AND;
            result   <= '0;
            carryout <= 1'b0;
            zero     <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                op_q  <= op;
                carry <= 1'b0;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_next;
            cnt    <= cnt + 1'b1;
            result <= res_next;
            if (last_bit) begin
                carryout <= c_next;
                zero     <= (res_next == '0);
            end
        end
    end

`ifdef SERIAL_LOGIC_UNIT_OVERFLOW_EN
    // At the last bit, carry holds the carry into the MSB and c_next the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (state == RUN && last_bit) begin
            overflow <= (op_q == OP_ADD) ? (carry ^ c_next) : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Randomized self-checking bench for serial_logic_unit against an arithmetic reference model.
module tb_serial_logic_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        op = 2'b00;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  result;
    logic              carryout;
    logic              zero;
`ifdef SERIAL_LOGIC_UNIT_OVERFLOW_EN
    logic              overflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_logic_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .zero      (zero)
`ifdef SERIAL_LOGIC_UNIT_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain word-level arithmetic, no bit-serial behaviour.
    task automatic model(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] r, output logic c, output logic ov);
        logic [WIDTH:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        c = 1'b0;
        ov = 1'b0;
        case (o)
            2'b00: r = x & y;
            2'b01: r = x | y;
            2'b10: r = x ^ y;
            default: begin
                r  = sum[WIDTH-1:0];
                c  = sum[WIDTH];
                ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input int stall, input bit garbage);
        logic [WIDTH-1:0] er;
        logic ec, eov;
        int k;
        model(o, x, y, er, ec, eov);
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("in_ready_idle", in_ready, 1);
        out_ready = (stall == 0);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_drop", in_ready, 0);
        k = 0;
        do begin
            in_valid = garbage && (k == 5);
            if (in_valid) begin
                a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            k++;
        end while (!out_valid && k < WIDTH + 8);
        in_valid = 1'b0;
        check("latency", k, WIDTH);
        check("result", result, er);
        check("carryout", carryout, ec);
        check("zero", zero, (er == '0));
`ifdef SERIAL_LOGIC_UNIT_OVERFLOW_EN
        check("overflow", overflow, eov);
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = garbage && (i == 1);
            @(posedge clk); #1;
            check("held_valid", out_valid, 1);
            check("held_result", result, er);
            check("held_carry", carryout, ec);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        int seen;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry", carryout, 0);
        check("rst_zero", zero, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'h0000000B, 32'h00000000, 0, 1'b0);
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0);
        run_op(2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1'b0);
        run_op(2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1'b0);
        run_op(2'b11, 32'h12345678, 32'h11111111, 5, 1'b1);
        run_op(2'b11, 32'h7FFFFFFF, 32'h00000001, 0, 1'b0);

        // Abort an ADD partway through with an asynchronous reset.
        op = 2'b11; a = 32'hDEADBEEF; b = 32'h01234567; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_carry", carryout, 0);
        check("abort_zero", zero, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (WIDTH + 10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run_op(2'b11, 32'h00000005, 32'h00000003, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic [WIDTH-1:0] x, y;
            x = $urandom;
            y = (t % 4 == 0) ? ~x : WIDTH'($urandom);
            run_op(2'($urandom_range(0, 3)), x, y, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
